// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types, defaults and address-error helper for the data-memory path
// Contents:
//   state_e        responder FSM states (IDLE / WAIT / RESP)
//   DEF_AW         default word-address width
//   DEF_LATENCY    default wait-state count
//   ERR_MISALIGN   error-reason bit: byte address not word aligned
//   ERR_RANGE      error-reason bit: address beyond the RAM
//   addr_err()     returns the error-reason mask for a byte address
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int DEF_AW      = 8;
    localparam int DEF_LATENCY = 2;

    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;

    // Range is judged on the full 32-bit address: any bit above the RAM's
    // byte span flags the access even though the index bits alias a real word.
    function automatic logic [1:0] addr_err(input logic [31:0] addr, input int aw);
        logic [1:0] reason;
        reason = 2'b00;
        if (addr[1:0] != 2'b00) begin
            reason = reason | ERR_MISALIGN;
        end
        if ((addr >> (aw + 2)) != 32'd0) begin
            reason = reason | ERR_RANGE;
        end
        return reason;
    endfunction

endpackage

// File: rtl/mips_dmem_array.sv
// rtl/mips_dmem_array.sv - single-port 2**AW x 32 data RAM with byte-lane writes
// Ports:
//   clk    in   clock; write and read both registered on the rising edge
//   we     in   write strobe
//   re     in   read strobe; rdata only changes on a read
//   idx    in   word index
//   be     in   byte-lane enables, be[i] -> bits 8i+7:8i
//   wdata  in   write data
//   rdata  out  registered read data, held between reads
module mips_dmem_array #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] idx,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];
    logic [31:0] rdata_q;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata_q <= mem[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mips_dmem_responder.sv
// rtl/mips_dmem_responder.sv - data-memory responder: request/response handshake with wait states
// Ports:
//   clk, reset_n            clock; asynchronous active-low reset
//   req_valid/req_ready     request handshake (req_ready registered, high only in IDLE)
//   req_write               1 = store, 0 = load
//   req_addr                byte address
//   req_wdata, req_be       store data and byte enables
//   resp_valid/resp_ready   response handshake (resp_valid registered)
//   resp_rdata              load data; 0 for stores and errors
//   resp_err                misaligned or out-of-range address
module mips_dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic          err_q, err_d;
    logic          req_ready_q, req_ready_d;
    logic          resp_valid_q, resp_valid_d;
    logic          resp_err_q, resp_err_d;
    logic          rd_sel_q, rd_sel_d;

    logic          accept, handshake, enter_resp;
    logic          cur_wr, cur_err;
    logic [AW-1:0] cur_idx;
    logic [31:0]   cur_wdata;
    logic [3:0]    cur_be;
    logic          arr_we, arr_re;
    logic [31:0]   arr_rdata;

    assign accept    = req_valid && req_ready_q;
    assign handshake = (state_q == ST_RESP) && resp_valid_q && resp_ready;

    // With LATENCY=0 RESP is entered on the accept edge itself, before the
    // request latches hold anything, so the access takes the live request.
    assign cur_wr    = accept ? req_write            : wr_q;
    assign cur_idx   = accept ? req_addr[AW+1:2]     : idx_q;
    assign cur_wdata = accept ? req_wdata            : wdata_q;
    assign cur_be    = accept ? req_be               : be_q;
    assign cur_err   = accept ? (addr_err(req_addr, AW) != 2'b00) : err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            wr_q         <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= 32'd0;
            be_q         <= 4'd0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rd_sel_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            err_q        <= err_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            rd_sel_q     <= rd_sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    wr_d    = cur_wr;
                    idx_d   = cur_idx;
                    wdata_d = cur_wdata;
                    be_d    = cur_be;
                    err_d   = cur_err;
                    if (LATENCY == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (handshake) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        enter_resp   = (state_d == ST_RESP) && (state_q != ST_RESP);
        arr_we       = enter_resp && cur_wr && !cur_err;
        arr_re       = enter_resp && !cur_wr && !cur_err;
        req_ready_d  = (state_d == ST_IDLE);
        // valid trails RESP entry by one edge so the registered RAM read is in place
        resp_valid_d = (state_q == ST_RESP) && (state_d == ST_RESP);
        resp_err_d   = resp_err_q;
        rd_sel_d     = rd_sel_q;
        if (enter_resp) begin
            resp_err_d = cur_err;
            rd_sel_d   = !cur_wr && !cur_err;
        end else if (handshake) begin
            resp_err_d = 1'b0;
            rd_sel_d   = 1'b0;
        end
    end

    mips_dmem_array #(.AW(AW)) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .idx   (cur_idx),
        .be    (cur_be),
        .wdata (cur_wdata),
        .rdata (arr_rdata)
    );

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    // RAM read register is only loaded on error-free loads; mask it otherwise
    assign resp_rdata = rd_sel_q ? arr_rdata : 32'd0;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// tb/tb_mips_dmem_responder.sv - bench for mips_dmem_responder at LATENCY=2 and LATENCY=0
module tb_mips_dmem_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        resp_valid[2];
    logic        resp_ready[2];
    logic [31:0] resp_rdata[2];
    logic        resp_err  [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mips_dmem_responder #(.AW(8), .LATENCY(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    mips_dmem_responder #(.AW(8), .LATENCY(0)) dut_l0 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: no DUT event within the cycle budget", name);
    endtask

    // ---------------- transaction-level reference model ----------------
    // Per instance: edges counted from the accept edge; the memory effect lands
    // LATENCY edges after accept and the response shows one edge later.
    int          lat_of [2] = '{2, 0};
    bit          m_ready[2], m_valid[2], m_busy[2], m_err[2], m_wr[2];
    int          m_n    [2];
    logic [31:0] m_addr [2], m_wdata[2], m_rdata[2], m_mask[2];
    logic [3:0]  m_be   [2];
    logic [31:0] m_mem  [2][256];
    logic [3:0]  m_kb   [2][256];

    task automatic model_commit(input int k);
        int w;
        bit bad;
        w   = int'(m_addr[k][9:2]);
        bad = (m_addr[k][1:0] != 2'b00) || (m_addr[k] >= 32'h400);
        m_err[k]   = bad;
        m_rdata[k] = 32'd0;
        m_mask[k]  = 32'hFFFF_FFFF;
        if (!bad && m_wr[k]) begin
            for (int b = 0; b < 4; b++) begin
                if (m_be[k][b]) m_mem[k][w][8*b +: 8] = m_wdata[k][8*b +: 8];
            end
            m_kb[k][w] = m_kb[k][w] | m_be[k];
        end else if (!bad) begin
            m_rdata[k] = m_mem[k][w];
            m_mask[k]  = {{8{m_kb[k][w][3]}}, {8{m_kb[k][w][2]}},
                          {8{m_kb[k][w][1]}}, {8{m_kb[k][w][0]}}};
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_ready[k] = 0; m_valid[k] = 0; m_busy[k] = 0; m_n[k] = 0;
            for (int i = 0; i < 256; i++) begin
                m_mem[k][i] = 32'd0;
                m_kb[k][i]  = 4'd0;
            end
        end
        forever begin
            @(posedge clk or negedge reset_n);
            for (int k = 0; k < 2; k++) begin
                if (!reset_n) begin
                    m_ready[k] = 0; m_valid[k] = 0; m_busy[k] = 0;
                end else if (m_valid[k]) begin
                    if (resp_ready[k]) begin
                        m_valid[k] = 0;
                        m_ready[k] = 1;
                    end
                end else if (m_busy[k]) begin
                    m_n[k]++;
                    if (m_n[k] == lat_of[k]) model_commit(k);
                    if (m_n[k] == lat_of[k] + 1) begin
                        m_valid[k] = 1;
                        m_busy[k]  = 0;
                    end
                end else if (m_ready[k] && req_valid[k]) begin
                    m_wr[k] = req_write[k]; m_addr[k] = req_addr[k];
                    m_wdata[k] = req_wdata[k]; m_be[k] = req_be[k];
                    m_busy[k] = 1; m_ready[k] = 0; m_n[k] = 0;
                    if (lat_of[k] == 0) model_commit(k);
                end else begin
                    m_ready[k] = 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!reset_n) begin
                    chk($sformatf("k%0d_rst_ready", k), 32'(req_ready[k]), 32'd0);
                    chk($sformatf("k%0d_rst_valid", k), 32'(resp_valid[k]), 32'd0);
                    chk($sformatf("k%0d_rst_rdata", k), resp_rdata[k], 32'd0);
                    chk($sformatf("k%0d_rst_err", k), 32'(resp_err[k]), 32'd0);
                end else begin
                    chk($sformatf("k%0d_req_ready", k), 32'(req_ready[k]), 32'(m_ready[k]));
                    chk($sformatf("k%0d_resp_valid", k), 32'(resp_valid[k]), 32'(m_valid[k]));
                    if (m_valid[k]) begin
                        chk($sformatf("k%0d_resp_err", k), 32'(resp_err[k]), 32'(m_err[k]));
                        chk($sformatf("k%0d_resp_rdata", k), resp_rdata[k] & m_mask[k],
                            m_rdata[k] & m_mask[k]);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input int k, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] be, input int hold,
                          output logic [31:0] rd, output logic err, output int lat);
        int t;
        req_valid[k] = 1'b1; req_write[k] = wr; req_addr[k] = addr;
        req_wdata[k] = wd;   req_be[k] = be;
        t = 0;
        while (!req_ready[k] && t < 50) begin
            step();
            t++;
        end
        if (t >= 50) timeout_fail("accept");
        step();
        req_valid[k] = 1'b0;
        req_write[k] = 1'($urandom); req_addr[k] = $urandom;
        req_wdata[k] = $urandom;     req_be[k] = 4'($urandom);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!resp_valid[k] && lat < 50);
        if (!resp_valid[k]) timeout_fail("resp_valid");
        rd  = resp_rdata[k];
        err = resp_err[k];
        for (int i = 0; i < hold; i++) begin
            // a competing request must wait out the pending response
            req_valid[k] = 1'b1; req_write[k] = 1'b0;
            req_addr[k]  = 32'($urandom_range(0, 15)) << 2;
            step();
            chk("hold_valid", 32'(resp_valid[k]), 32'd1);
            chk("hold_rdata", resp_rdata[k], rd);
            chk("hold_err", 32'(resp_err[k]), 32'(err));
            chk("hold_req_ready", 32'(req_ready[k]), 32'd0);
        end
        req_valid[k]  = 1'b0;
        resp_ready[k] = 1'b1;
        step();
        resp_ready[k] = 1'b0;
    endtask

    logic [31:0] rd, addr;
    logic        er;
    int          lat, sel;

    initial begin
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 0; req_write[k] = 0; req_addr[k] = 0;
            req_wdata[k] = 0; req_be[k] = 0; resp_ready[k] = 0;
        end
        #1 reset_n = 1'b0;
        repeat (3) step();
        chk("rst_ready0", 32'(req_ready[0]), 32'd0);
        chk("rst_valid0", 32'(resp_valid[0]), 32'd0);
        reset_n = 1'b1;
        step();
        chk("rel_ready0", 32'(req_ready[0]), 32'd1);
        chk("rel_ready1", 32'(req_ready[1]), 32'd1);

        do_txn(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
        chk("st_lat", 32'(lat), 32'd3);
        chk("st_err", 32'(er), 32'd0);
        chk("st_rdata", rd, 32'd0);
        do_txn(0, 0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
        chk("ld_lat", 32'(lat), 32'd3);
        chk("ld_rdata", rd, 32'hDEADBEEF);
        do_txn(0, 1, 32'h10, 32'h11223344, 4'b0101, 0, rd, er, lat);
        do_txn(0, 0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
        chk("be_rdata", rd, 32'hDE22BE44);
        do_txn(0, 0, 32'h12, 32'h0, 4'h0, 0, rd, er, lat);
        chk("mis_err", 32'(er), 32'd1);
        chk("mis_rdata", rd, 32'd0);
        do_txn(0, 1, 32'h0, 32'h01020304, 4'hF, 0, rd, er, lat);
        do_txn(0, 1, 32'h400, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat);
        chk("rng_err", 32'(er), 32'd1);
        do_txn(0, 0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat);
        chk("rng_no_write", rd, 32'h01020304);
        do_txn(0, 0, 32'h10, 32'h0, 4'h0, 5, rd, er, lat);
        chk("bp_rdata", rd, 32'hDE22BE44);

        // reset while the store is still in its wait states
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h10;
        req_wdata[0] = 32'hCAFEF00D; req_be[0] = 4'hF;
        step();
        req_valid[0] = 1'b0;
        step();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
        do_txn(0, 0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
        chk("rst_mid_rdata", rd, 32'hDE22BE44);

        do_txn(1, 1, 32'h20, 32'h55AA55AA, 4'hF, 0, rd, er, lat);
        chk("l0_st_lat", 32'(lat), 32'd1);
        do_txn(1, 1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, rd, er, lat);
        do_txn(1, 0, 32'h20, 32'h0, 4'h0, 2, rd, er, lat);
        chk("l0_ld_lat", 32'(lat), 32'd1);
        chk("l0_be0_rdata", rd, 32'h55AA55AA);

        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 60; n++) begin
                sel = $urandom_range(0, 9);
                if (sel <= 6)      addr = 32'($urandom_range(0, 15)) << 2;
                else if (sel == 7) addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
                else if (sel == 8) addr = $urandom | 32'h400;
                else               addr = 32'h3FC;
                do_txn(k, 1'($urandom), addr, $urandom, 4'($urandom),
                       $urandom_range(0, 3), rd, er, lat);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
